alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

- Decode-to-execute issue stage that drives the 32-bit pipeline ALU.
- Decodes RV32 opcode/funct fields into the 4-bit ALU operation code, selects and registers the operands, and holds them in an ID/EX register under a valid/ready handshake.
- Consumes the ALU `zero` flag to resolve `beq`, then issues a one-cycle redirect and squashes wrong-path instructions.
- Sits between the decode stage and the ALU in the 5-stage pipeline.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating taken-branch counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  decode offers an instruction
- `in_ready`  out  1  stage accepts the offered instruction this cycle
- `opcode`  in  7  instruction[6:0]
- `funct3`  in  3  instruction[14:12]
- `funct7_5`  in  1  instruction[30]
- `rs1_data`, `rs2_data`  in  32  register-file read data
- `imm`  in  32  sign-extended immediate
- `pc`  in  32  instruction address
- `rd`  in  5  destination register
- `flush`  in  1  external synchronous squash from the hazard unit
- `ex_ready`  in  1  downstream (EX/MEM) can take the held instruction
- `alu_zero`  in  1  ALU zero flag for the currently held operands
- `ex_valid`  out  1  held instruction is valid
- `alu_a`, `alu_b`  out  32  registered ALU operands
- `alu_op`  out  4  registered ALU operation code
- `ex_rd`  out  5  registered destination register
- `ex_is_branch`  out  1  held instruction is `beq`
- `branch_taken`  out  1  one-cycle redirect pulse
- `branch_target`  out  32  redirect address, valid while `branch_taken` = 1
- `illegal_insn`  out  1  one-cycle pulse for an accepted unsupported encoding
- `taken_count`  out  CNT_W  saturating count of taken branches

## Operation
Decode table for `alu_op`, with `alu_b` selection:
- R-type (`opcode` = 0110011):
  - funct3 000, funct7_5 = 0 -> 0010 (add)
  - funct3 000, funct7_5 = 1 -> 0110 (sub)
  - funct3 111 -> 0000 (and)
  - funct3 110 -> 0001 (or)
  - funct3 010 -> 0111 (slt)
  - `alu_b` = `rs2_data`
- I-type ALU (0010011): same mapping for funct3 000/111/110/010, with funct7_5 ignored; `alu_b` = `imm`.
- Load (0000011) and store (0100011): 0010; `alu_b` = `imm`.
- `beq` (1100011, funct3 000): 0110; `alu_b` = `rs2_data`; `ex_is_branch` = 1; branch target `pc + imm` (32-bit, wraps mod 2^32) is captured internally.
- Any other encoding is illegal:
  - `illegal_insn` pulses next cycle.
  - The register loads a bubble (`ex_valid` = 0).
  - `alu_op` is set to 1111.

`alu_a` = `rs1_data` in all cases.

Register update priority, evaluated at each rising edge:
1. `!rst_n`: reset.
2. `flush`: `ex_valid` <= 0, `branch_taken` <= 0.
3. Taken-branch resolve (`ex_valid` & `ex_is_branch` & `alu_zero` & `ex_ready`):
   - `branch_taken` <= 1; `branch_target` <= captured target.
   - The instruction accepted in the same cycle is discarded; `ex_valid` <= 0.
   - `taken_count` increments, saturating at all-ones.
4. `branch_taken` = 1: any accepted input is discarded (second wrong-path slot); `ex_valid` <= 0.
5. Accept (`in_valid` & `in_ready`): load the decoded fields; `ex_valid` <= 1 unless illegal.
6. `ex_ready` & !accept: `ex_valid` <= 0.
7. Otherwise: hold all registers.

Handshake and pulses:
- `in_ready` = !`ex_valid` | `ex_ready` (combinational); also 1 while `branch_taken` = 1.
- `branch_taken` and `illegal_insn` are single-cycle and auto-clear unless re-triggered.

Reset values (all outputs):
- `ex_valid` 0, `alu_a` 0, `alu_b` 0, `alu_op` 0000, `ex_rd` 0, `ex_is_branch` 0.
- `branch_taken` 0, `branch_target` 0, `illegal_insn` 0, `taken_count` 0.
- `in_ready` reads 1 from the first cycle after reset.

## Timing
- Issue latency: 1 cycle from accept to `ex_valid`/`alu_*`.
- Back-to-back accepts sustain 1 instruction/cycle when `ex_ready` = 1.
- `alu_zero` is sampled in the cycle the branch is held with `ex_ready` = 1.
- `branch_taken` asserts the following cycle, for exactly 1 cycle.
- Stall (`ex_valid` = 1, `ex_ready` = 0): all `alu_*`/`ex_*` outputs stable, `in_ready` = 0, and no branch resolves even if `alu_zero` = 1.
- Simultaneous events:
  - `flush` with resolve: no redirect.
  - `flush` with accept: input is dropped.
  - `rst_n` low overrides everything.
  - Reset mid-stall loses the held instruction.
- Not-taken `beq` (`alu_zero` = 0) retires like any other instruction, with no squash.

## Test plan
- Reset, then `add` (0110011/000/0) with a = 5, b = 7 -> next cycle `alu_op` 0010, `alu_a` 5, `alu_b` 7, `ex_valid` 1.
- `addi` with `imm` = 0xFFFFFFFF, then `sub` (funct7_5 = 1) -> `alu_b` = 0xFFFFFFFF then `rs2_data`; `alu_op` 0010 then 0110 on consecutive cycles.
- Stall: hold `ex_ready` = 0 for 3 cycles with `in_valid` = 1 -> `in_ready` 0 and outputs unchanged; release -> next instruction loads the following cycle.
- `beq` at `pc` 0x100, `imm` 0x20, `alu_zero` = 1, with `in_valid` held high -> `branch_taken` 1 for one cycle with `branch_target` 0x120; the next two accepted instructions are squashed; `taken_count` = 1.
- `beq` with `alu_zero` = 0 -> no `branch_taken`; the following instruction issues normally.
- Opcode 1110011 -> `illegal_insn` pulse, `ex_valid` 0; `flush` asserted together with a resolving branch -> no redirect and `ex_valid` 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32 ALU/load/store/beq into ALU controls,
// registers operands, resolves beq from alu_zero and squashes wrong path.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [31:0]      imm,
  input  logic [31:0]      pc,
  input  logic [4:0]       rd,
  input  logic             flush,
  input  logic             ex_ready,
  input  logic             alu_zero,
  output logic             ex_valid,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       ex_rd,
  output logic             ex_is_branch,
  output logic             branch_taken,
  output logic [31:0]      branch_target,
  output logic             illegal_insn,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  function automatic logic [3:0] alu_fn(
    input logic [2:0] f3,
    input logic       sub
  );
    case (f3)
      3'b000:  return sub ? ALU_SUB : ALU_ADD;
      3'b111:  return ALU_AND;
      3'b110:  return ALU_OR;
      3'b010:  return ALU_SLT;
      default: return ALU_BAD;
    endcase
  endfunction

  logic        is_r;
  logic        is_i;
  logic        is_ls;
  logic        is_br;
  logic [3:0]  dec_op;
  logic        dec_imm;
  logic        dec_br;
  logic        dec_ill;
  logic        accept;
  logic        resolve;
  logic [31:0] tgt_q;

  assign is_r  = (opcode == OPC_R);
  assign is_i  = (opcode == OPC_I);
  assign is_ls = (opcode == OPC_LD) || (opcode == OPC_ST);
  assign is_br = (opcode == OPC_BR);

  always_comb begin
    dec_op  = ALU_BAD;
    dec_imm = 1'b0;
    dec_br  = 1'b0;
    unique case (1'b1)
      is_r: begin
        dec_op = alu_fn(funct3, funct7_5);
      end
      is_i: begin
        dec_op  = alu_fn(funct3, 1'b0);
        dec_imm = 1'b1;
      end
      is_ls: begin
        dec_op  = ALU_ADD;
        dec_imm = 1'b1;
      end
      is_br: begin
        if (funct3 == 3'b000) begin
          dec_op = ALU_SUB;
          dec_br = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign dec_ill  = (dec_op == ALU_BAD);
  assign in_ready = !ex_valid || ex_ready || branch_taken;
  assign accept   = in_valid && in_ready;
  assign resolve  = ex_valid && ex_is_branch && alu_zero && ex_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_op        <= 4'b0000;
      ex_rd         <= '0;
      ex_is_branch  <= 1'b0;
      branch_taken  <= 1'b0;
      branch_target <= '0;
      illegal_insn  <= 1'b0;
      taken_count   <= '0;
      tgt_q         <= '0;
    end else begin
      branch_taken <= 1'b0;
      illegal_insn <= 1'b0;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (resolve) begin
        branch_taken  <= 1'b1;
        branch_target <= tgt_q;
        ex_valid      <= 1'b0;
        if (taken_count != '1)
          taken_count <= taken_count + 1'b1;
      end else if (branch_taken) begin
        // second wrong-path slot after the redirect
        ex_valid <= 1'b0;
      end else if (accept) begin
        ex_valid     <= !dec_ill;
        illegal_insn <= dec_ill;
        alu_a        <= rs1_data;
        alu_b        <= dec_imm ? imm : rs2_data;
        alu_op       <= dec_op;
        ex_rd        <= rd;
        ex_is_branch <= dec_br;
        tgt_q        <= pc + imm;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: mnemonic-level model feeds scoreboard
// queues; a negedge monitor pops and compares what the DUT presents.
module tb_alu_issue_stage;

  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic [31:0]   rs1_data;
  logic [31:0]   rs2_data;
  logic [31:0]   imm;
  logic [31:0]   pc;
  logic [4:0]    rd;
  logic          flush;
  logic          ex_ready;
  logic          alu_zero;
  logic          ex_valid;
  logic [31:0]   alu_a;
  logic [31:0]   alu_b;
  logic [3:0]    alu_op;
  logic [4:0]    ex_rd;
  logic          ex_is_branch;
  logic          branch_taken;
  logic [31:0]   branch_target;
  logic          illegal_insn;
  logic [CW-1:0] taken_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .rd(rd),
    .flush(flush), .ex_ready(ex_ready), .alu_zero(alu_zero),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .ex_rd(ex_rd), .ex_is_branch(ex_is_branch),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .illegal_insn(illegal_insn), .taken_count(taken_count)
  );

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT,
    K_ADDI, K_ANDI, K_ORI, K_SLTI,
    K_LW, K_SW, K_BEQ, K_ILL
  } kind_e;

  typedef struct {
    kind_e       k;
    int          sel;
    logic        f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
  } ins_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        br;
  } exp_t;

  typedef struct {
    int   due;
    exp_t e;
  } rq_t;

  typedef struct {
    int          due;
    logic [31:0] tgt;
    int          cnt;
  } bq_t;

  rq_t rq[$];
  bq_t bq[$];
  int  iq[$];

  int checks = 0;
  int errors = 0;
  int cycno  = 0;
  bit mon_en = 1'b0;

  exp_t        mh;
  logic [31:0] mtgt;
  bit          mv;
  bit          mbt;
  int          mcnt;

  always @(posedge clk) cycno <= cycno + 1;

  function automatic void chk(string n, logic [127:0] act,
                              logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endfunction

  function automatic ins_t mk(kind_e k, logic [31:0] a, logic [31:0] b,
                              logic [31:0] i, logic [31:0] p,
                              logic [4:0] d);
    ins_t x;
    x.k = k; x.sel = 0; x.f7 = 1'b0;
    x.rs1 = a; x.rs2 = b; x.imm = i; x.pc = p; x.rd = d;
    return x;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t x;
    x.k   = kind_e'($urandom_range(0, 12));
    x.sel = int'($urandom_range(0, 4));
    x.f7  = 1'($urandom_range(0, 1));
    x.rs1 = $urandom;
    x.rs2 = $urandom;
    x.imm = $urandom;
    x.pc  = $urandom;
    x.rd  = 5'($urandom);
    if (x.k == K_BEQ && $urandom_range(0, 1) == 1) x.rs2 = x.rs1;
    return x;
  endfunction

  task automatic encode(input ins_t x, output logic [6:0] o,
                        output logic [2:0] f3, output logic f7);
    logic [6:0] ill_o[5];
    logic [2:0] ill_f[5];
    ill_o = '{7'b1110011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111};
    ill_f = '{3'b000, 3'b001, 3'b100, 3'b001, 3'b000};
    f7 = 1'b0;
    case (x.k)
      K_ADD:  begin o = 7'b0110011; f3 = 3'b000; end
      K_SUB:  begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
      K_AND:  begin o = 7'b0110011; f3 = 3'b111; end
      K_OR:   begin o = 7'b0110011; f3 = 3'b110; end
      K_SLT:  begin o = 7'b0110011; f3 = 3'b010; end
      K_ADDI: begin o = 7'b0010011; f3 = 3'b000; f7 = x.f7; end
      K_ANDI: begin o = 7'b0010011; f3 = 3'b111; f7 = x.f7; end
      K_ORI:  begin o = 7'b0010011; f3 = 3'b110; f7 = x.f7; end
      K_SLTI: begin o = 7'b0010011; f3 = 3'b010; f7 = x.f7; end
      K_LW:   begin o = 7'b0000011; f3 = 3'b010; f7 = x.f7; end
      K_SW:   begin o = 7'b0100011; f3 = 3'b010; f7 = x.f7; end
      K_BEQ:  begin o = 7'b1100011; f3 = 3'b000; end
      default: begin o = ill_o[x.sel]; f3 = ill_f[x.sel]; end
    endcase
  endtask

  function automatic exp_t model_of(ins_t x);
    exp_t e;
    bit   use_imm;
    use_imm = x.k inside {K_ADDI, K_ANDI, K_ORI, K_SLTI, K_LW, K_SW};
    case (x.k)
      K_ADD, K_ADDI, K_LW, K_SW: e.op = 4'b0010;
      K_SUB, K_BEQ:              e.op = 4'b0110;
      K_AND, K_ANDI:             e.op = 4'b0000;
      K_OR, K_ORI:               e.op = 4'b0001;
      K_SLT, K_SLTI:             e.op = 4'b0111;
      default:                   e.op = 4'b1111;
    endcase
    e.a  = x.rs1;
    e.b  = use_imm ? x.imm : x.rs2;
    e.rd = x.rd;
    e.br = (x.k == K_BEQ);
    return e;
  endfunction

  // One clock: drive at posedge+1, advance the model, return at next posedge+1
  task automatic cyc(input bit rst, input bit iv, input ins_t x,
                     input bit exr, input bit fl);
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    bit         rdy;
    bit         acc;
    exp_t       e;
    encode(x, o, f3, f7);
    rst_n    = !rst;
    in_valid = iv;
    opcode   = o;
    funct3   = f3;
    funct7_5 = f7;
    rs1_data = x.rs1;
    rs2_data = x.rs2;
    imm      = x.imm;
    pc       = x.pc;
    rd       = x.rd;
    ex_ready = exr;
    flush    = fl;
    alu_zero = (mv && mh.br) ? (mh.a == mh.b) : 1'($urandom_range(0, 1));
    #1;
    rdy = !mv || exr || mbt;
    chk("in_ready", in_ready, rdy);
    acc = iv && rdy;
    e   = model_of(x);
    if (mv && exr) rq.push_back('{cycno, mh});
    if (rst) begin
      mv = 0; mbt = 0; mh = '0; mcnt = 0; mtgt = '0;
    end else if (fl) begin
      mv = 0; mbt = 0;
    end else if (mv && mh.br && alu_zero && exr) begin
      mbt = 1; mv = 0;
      if (mcnt < MAXC) mcnt++;
      bq.push_back('{cycno + 1, mtgt, mcnt});
    end else if (mbt) begin
      mv = 0; mbt = 0;
    end else if (acc) begin
      mbt  = 0;
      mh   = e;
      mtgt = x.pc + x.imm;
      mv   = (x.k != K_ILL);
      if (x.k == K_ILL) iq.push_back(cycno + 1);
    end else begin
      mbt = 0;
      if (exr) mv = 0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    rq_t r;
    bq_t b;
    if (mon_en) begin
      if (rq.size() > 0 && rq[0].due == cycno) begin
        r = rq.pop_front();
        chk("retire_handshake", {ex_valid, ex_ready}, 2'b11);
        chk("retire_fields",
            {alu_a, alu_b, alu_op, ex_rd, ex_is_branch}, r.e);
      end else begin
        chk("unexpected_retire", ex_valid && ex_ready, 1'b0);
      end
      if (bq.size() > 0 && bq[0].due == cycno) begin
        b = bq.pop_front();
        chk("branch_taken", branch_taken, 1'b1);
        chk("branch_target", branch_target, b.tgt);
        chk("taken_count", taken_count, b.cnt);
      end else begin
        chk("unexpected_branch", branch_taken, 1'b0);
      end
      if (iq.size() > 0 && iq[0] == cycno) begin
        void'(iq.pop_front());
        chk("illegal_pulse", illegal_insn, 1'b1);
        chk("illegal_bubble", {ex_valid, alu_op}, 5'h0f);
      end else begin
        chk("unexpected_illegal", illegal_insn, 1'b0);
      end
    end
  end

  initial begin
    ins_t idle;
    idle = mk(K_ADD, 0, 0, 0, 0, 0);
    mv = 0; mbt = 0; mh = '0; mcnt = 0; mtgt = '0;
    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; funct3 = '0;
    funct7_5 = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
    pc = '0; rd = '0; flush = 1'b0; ex_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    cyc(1, 0, idle, 0, 0);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", alu_op, 4'h0);
    chk("rst_ex_rd", ex_rd, 5'h0);
    chk("rst_is_branch", ex_is_branch, 1'b0);
    chk("rst_branch_taken", branch_taken, 1'b0);
    chk("rst_branch_target", branch_target, 32'h0);
    chk("rst_illegal", illegal_insn, 1'b0);
    chk("rst_taken_count", taken_count, 0);
    chk("rst_in_ready", in_ready, 1'b1);

    cyc(0, 1, mk(K_ADD, 5, 7, 0, 0, 3), 1, 0);
    chk("add_issue", {ex_valid, alu_op, alu_a, alu_b},
        {1'b1, 4'b0010, 32'd5, 32'd7});

    cyc(0, 1, mk(K_ADDI, 4, 9, 32'hffffffff, 0, 4), 1, 0);
    chk("addi_b", {alu_op, alu_b}, {4'b0010, 32'hffffffff});
    cyc(0, 1, mk(K_SUB, 4, 32'h1234, 32'hffffffff, 0, 5), 1, 0);
    chk("sub_b", {alu_op, alu_b}, {4'b0110, 32'h1234});

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, mk(K_AND, 8, 9, 0, 0, 6), 0, 0);
      chk("stall_hold", {ex_valid, alu_op, alu_b, ex_rd},
          {1'b1, 4'b0110, 32'h1234, 5'd5});
    end
    cyc(0, 1, mk(K_AND, 8, 9, 0, 0, 6), 1, 0);
    chk("stall_release", {ex_valid, alu_op, ex_rd}, {1'b1, 4'b0000, 5'd6});

    cyc(0, 1, mk(K_BEQ, 9, 9, 32'h20, 32'h100, 0), 1, 0);
    cyc(0, 1, mk(K_ADD, 1, 2, 0, 0, 7), 1, 0);
    chk("beq_redirect", {branch_taken, branch_target, ex_valid},
        {1'b1, 32'h120, 1'b0});
    chk("beq_count", taken_count, 1);
    cyc(0, 1, mk(K_OR, 1, 2, 0, 0, 8), 1, 0);
    chk("beq_slot2", {branch_taken, ex_valid}, 2'b00);
    cyc(0, 1, mk(K_SLT, 1, 2, 0, 0, 9), 1, 0);
    chk("beq_resume", {ex_valid, alu_op}, {1'b1, 4'b0111});

    cyc(0, 1, mk(K_BEQ, 1, 2, 32'h40, 32'h200, 0), 1, 0);
    cyc(0, 1, mk(K_ADD, 3, 4, 0, 0, 10), 1, 0);
    chk("beq_not_taken", {branch_taken, ex_valid, alu_op},
        {1'b0, 1'b1, 4'b0010});

    cyc(0, 1, mk(K_ILL, 1, 2, 3, 0, 11), 1, 0);
    chk("illegal_now", {illegal_insn, ex_valid, alu_op},
        {1'b1, 1'b0, 4'b1111});
    cyc(0, 0, idle, 1, 0);
    chk("illegal_clear", illegal_insn, 1'b0);

    cyc(0, 1, mk(K_BEQ, 3, 3, 32'h8, 32'h300, 0), 1, 0);
    cyc(0, 1, mk(K_ADD, 3, 4, 0, 0, 12), 1, 1);
    chk("flush_resolve", {branch_taken, ex_valid}, 2'b00);

    cyc(0, 1, mk(K_ADD, 7, 7, 0, 0, 13), 0, 0);
    cyc(0, 0, idle, 0, 0);
    cyc(1, 0, idle, 0, 0);
    chk("reset_stall", {ex_valid, alu_a, taken_count},
        {1'b0, 32'h0, {CW{1'b0}}});

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 399) == 0, $urandom_range(0, 4) != 0,
          rnd_ins(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0);
    end
    repeat (4) cyc(0, 0, idle, 1, 0);

    chk("retire_queue_empty", rq.size(), 0);
    chk("branch_queue_empty", bq.size(), 0);
    chk("illegal_queue_empty", iq.size(), 0);
    chk("final_taken_count", taken_count, mcnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
